// File: rtl/gnn_pkg.sv
// Constants and FSM state type shared between the GNN top level and its result collector.
package gnn_pkg;

   localparam int GNN_NODES = 4;
   localparam int GNN_OUTS  = 2;
   localparam int GNN_DW    = 21;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DRAIN  = 2'd3
   } gnn_state_t;

endpackage

// File: rtl/gnn_stream_out.sv
// Output stage: walks the result buffer word by word, holding the word steady under backpressure.
module gnn_stream_out #(
   parameter int N  = 8,
   parameter int DW = 21,
   parameter int IW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [N*DW-1:0] words,
   input  logic            m_ready,
   output logic            m_valid,
   output logic [DW-1:0]   m_data,
   output logic [IW-1:0]   m_idx,
   output logic            m_last,
   output logic            fin
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [IW-1:0] idx_nxt;

   assign idx_nxt = m_idx + IW'(1);
   assign fin     = m_valid & m_ready & m_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_idx   <= '0;
         m_last  <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= words[0 +: DW];
         m_idx   <= '0;
         m_last  <= (N == 1);
      end else if (m_valid && m_ready) begin
         if (m_last) begin
            m_valid <= 1'b0;
         end else begin
            m_data <= words[idx_nxt*DW +: DW];
            m_idx  <= idx_nxt;
            m_last <= (idx_nxt == LAST_IDX);
         end
      end
   end

endmodule

// File: rtl/gnn_result_collector.sv
// Launches one GNN inference, captures each result on its first ready flag, then streams them out in index order.
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_LAUNCH | in_ready pulse to the GNN
//   ST_WAIT   | capturing results, timeout counter running
//   ST_DRAIN  | streaming buffer[0..N-1]
module gnn_result_collector
   import gnn_pkg::*;
#(
   parameter int NODES   = GNN_NODES,
   parameter int OUTS    = GNN_OUTS,
   parameter int DW      = GNN_DW,
   parameter int TIMEOUT = 255
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             in_ready,
   input  logic [NODES*OUTS-1:0]            res_rdy,
   input  logic [NODES*OUTS*DW-1:0]         res_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [DW-1:0]                    m_data,
   output logic [$clog2(NODES*OUTS)-1:0]    m_idx,
   output logic                             m_last,
   output logic                             busy,
   output logic                             done,
   output logic                             err
);

   localparam int N  = NODES * OUTS;
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT + 1);

   gnn_state_t      state;
   logic [N-1:0]    captured;
   logic [N*DW-1:0] buffer;
   logic [N*DW-1:0] buf_view;
   logic [CW-1:0]   tcnt;
   logic [CW-1:0]   tcnt_nxt;
   logic            mask_full;
   logic            load;
   logic            fin;

   // Slices captured this very cycle come straight from res_data so word 0 is right on the WAIT->DRAIN edge.
   always_comb begin
      buf_view = buffer;
      for (int k = 0; k < N; k++) begin
         if (!captured[k]) buf_view[k*DW +: DW] = res_data[k*DW +: DW];
      end
   end

   assign mask_full = &(captured | res_rdy);
   assign load      = (state == ST_WAIT) && mask_full;
   assign tcnt_nxt  = tcnt + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         captured <= '0;
         buffer   <= '0;
         tcnt     <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         in_ready <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_LAUNCH;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  captured <= '0;
                  tcnt     <= '0;
               end
            end
            ST_LAUNCH: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               for (int k = 0; k < N; k++) begin
                  if (res_rdy[k] && !captured[k]) buffer[k*DW +: DW] <= res_data[k*DW +: DW];
               end
               captured <= captured | res_rdy;
               tcnt     <= tcnt_nxt;
               // Completion takes priority over a timeout landing on the same cycle.
               if (mask_full) begin
                  state <= ST_DRAIN;
               end else if (tcnt_nxt == CW'(TIMEOUT)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (fin) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   gnn_stream_out #(
      .N  (N),
      .DW (DW),
      .IW (IW)
   ) u_stream_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .words   (buf_view),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_idx   (m_idx),
      .m_last  (m_last),
      .fin     (fin)
   );

endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed bench for gnn_result_collector: capture, staggered flags, backpressure, timeout, reset abort.
module tb_gnn_result_collector;

   localparam int NODES   = 4;
   localparam int OUTS    = 2;
   localparam int DW      = 21;
   localparam int TIMEOUT = 10;
   localparam int N       = NODES * OUTS;
   localparam int IW      = 3;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            in_ready;
   logic [N-1:0]    res_rdy;
   logic [N*DW-1:0] res_data;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_data;
   logic [IW-1:0]   m_idx;
   logic            m_last;
   logic            busy;
   logic            done;
   logic            err;

   int checks = 0;
   int errors = 0;

   gnn_result_collector #(
      .NODES   (NODES),
      .OUTS    (OUTS),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_ready (in_ready),
      .res_rdy  (res_rdy),
      .res_data (res_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_idx    (m_idx),
      .m_last   (m_last),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
      chk({tag, "_m_data"},   32'(m_data),   32'd0);
      chk({tag, "_m_idx"},    32'(m_idx),    32'd0);
      chk({tag, "_m_last"},   32'(m_last),   32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_err"},      32'(err),      32'd0);
   endtask

   task automatic set_all(input int base);
      for (int k = 0; k < N; k++) res_data[k*DW +: DW] = DW'(base + k);
   endtask

   // Returns mid WAIT cycle 1: inputs driven now are seen at the end of that cycle.
   task automatic launch();
      start = 1'b1;
      tick();
      chk("launch_in_ready", 32'(in_ready), 32'd1);
      chk("launch_busy", 32'(busy), 32'd1);
      chk("done_one_cycle", 32'(done), 32'd0);
      start = 1'b0;
      tick();
      chk("in_ready_one_cycle", 32'(in_ready), 32'd0);
   endtask

   // Consumes the stream from the current cycle; expects word k = base + k. Returns on the done cycle.
   task automatic run_drain(input string tag, input int base, input bit bp);
      int got = 0;
      int it = 0;
      logic prev_stall = 1'b0;
      logic [DW-1:0] pd = '0;
      logic [IW-1:0] pi = '0;
      while (got < N && it < 100) begin
         if (prev_stall) begin
            chk({tag, "_hold_data"}, 32'(m_data), 32'(pd));
            chk({tag, "_hold_idx"}, 32'(m_idx), 32'(pi));
         end
         if (m_valid) begin
            m_ready = bp ? ((it % 3) == 0) : 1'b1;
            if (m_ready) begin
               chk({tag, "_data"}, 32'(m_data), 32'(base + got));
               chk({tag, "_idx"}, 32'(m_idx), 32'(got));
               chk({tag, "_last"}, 32'(m_last), (got == N - 1) ? 32'd1 : 32'd0);
               got++;
            end
            prev_stall = !m_ready;
            pd = m_data;
            pi = m_idx;
         end else begin
            prev_stall = 1'b0;
         end
         it++;
         tick();
      end
      chk({tag, "_word_count"}, 32'(got), 32'(N));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_valid_after"}, 32'(m_valid), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      m_ready = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      res_rdy  = '0;
      res_data = '0;
      m_ready  = 1'b1;
      #1;
      chk_reset_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: all flags together at WAIT cycle 3
      launch();
      tick();
      tick();
      set_all(100);
      res_rdy = '1;
      tick();
      res_rdy = '0;
      set_all(900);
      run_drain("s1", 100, 1'b0);

      // 2: staggered flags 7..0, each value corrupted after capture; start coincides with done
      launch();
      for (int i = 0; i < N; i++) begin
         if (i > 0) begin
            res_rdy[N - i] = 1'b0;
            res_data[(N - i)*DW +: DW] = DW'(600 + N - i);
         end
         res_rdy[N - 1 - i] = 1'b1;
         res_data[(N - 1 - i)*DW +: DW] = DW'(200 + N - 1 - i);
         tick();
      end
      res_rdy = '0;
      set_all(600);
      run_drain("s2", 200, 1'b0);

      // 3: backpressure 1,0,0,1,...
      launch();
      set_all(300);
      res_rdy = '1;
      tick();
      res_rdy = '0;
      run_drain("s3", 300, 1'b1);

      // 4: timeout with 7 of 8 flags
      tick();
      launch();
      set_all(50);
      res_rdy = 8'h7F;
      for (int c = 1; c < TIMEOUT; c++) begin
         tick();
         chk("s4_no_valid", 32'(m_valid), 32'd0);
      end
      chk("s4_err_before", 32'(err), 32'd0);
      tick();
      chk("s4_err", 32'(err), 32'd1);
      chk("s4_busy", 32'(busy), 32'd0);
      chk("s4_valid", 32'(m_valid), 32'd0);
      res_rdy = '0;
      tick();
      chk("s4_err_sticky", 32'(err), 32'd1);

      // 5: last flag on exactly the timeout cycle
      launch();
      chk("s5_err_cleared", 32'(err), 32'd0);
      set_all(400);
      res_rdy = 8'h7F;
      for (int c = 1; c < TIMEOUT; c++) tick();
      res_rdy = '1;
      tick();
      res_rdy = '0;
      chk("s5_err", 32'(err), 32'd0);
      chk("s5_drain", 32'(m_valid), 32'd1);
      run_drain("s5", 400, 1'b0);

      // 6: reset after word 3
      tick();
      launch();
      set_all(500);
      res_rdy = '1;
      tick();
      res_rdy = '0;
      for (int w = 0; w < 4; w++) begin
         chk("s6_pre_idx", 32'(m_idx), 32'(w));
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("s6_reset");
      tick();
      rst_n = 1'b1;
      tick();
      chk("s6_no_done", 32'(done), 32'd0);
      chk("s6_no_valid", 32'(m_valid), 32'd0);
      launch();
      set_all(700);
      res_rdy = '1;
      tick();
      res_rdy = '0;
      run_drain("s6", 700, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gnn_result_collector.md
GNN_RESULT_COLLECTOR -- requirements
Module: gnn_result_collector

Interface
REQ-001 SHALL have parameter NODES, default 4: number of graph nodes.
REQ-002 SHALL have parameter OUTS, default 2: outputs per node.
REQ-003 SHALL have parameter DW, default 21: result width in bits.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in WAIT.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port start, input, 1 bit: host request to run one inference.
REQ-008 SHALL have port in_ready, output, 1 bit: launch pulse to the GNN.
REQ-009 SHALL have port res_rdy, input, NODES*OUTS bits: GNN per-result ready flags. Bit k = node k/OUTS, output k%OUTS.
REQ-010 SHALL have port res_data, input, NODES*OUTS*DW bits: GNN results. Slice k is bits [k*DW +: DW].
REQ-011 SHALL have port m_valid, output, 1 bit: stream word valid.
REQ-012 SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-013 SHALL have port m_data, output, DW bits: stream result word.
REQ-014 SHALL have port m_idx, output, clog2(NODES*OUTS) bits: result index k.
REQ-015 SHALL have port m_last, output, 1 bit: marks the final word, k = NODES*OUTS-1.
REQ-016 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-018 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-019 SHALL implement an FSM with states IDLE, LAUNCH, WAIT, DRAIN.
REQ-020 IDLE: start=1 -> LAUNCH. Entering LAUNCH clears err, the captured mask, and the timeout counter.
REQ-021 LAUNCH: in_ready=1 for exactly one cycle -> WAIT.
REQ-022 WAIT: for each k with res_rdy[k]=1 and captured[k]=0, latch slice k into buffer[k] and set captured[k]. Later toggles of that flag are ignored.
REQ-023 WAIT: when all captured bits are set, including bits set this cycle -> DRAIN with index 0.
REQ-024 WAIT: the timeout counter increments each cycle. On reaching TIMEOUT with the mask incomplete, set err=1 -> IDLE; no words are streamed.
REQ-025 If the mask completes in the same cycle the counter reaches TIMEOUT, completion wins -> DRAIN, err stays 0.
REQ-026 DRAIN: m_valid=1, m_data=buffer[idx], m_idx=idx, m_last=(idx==NODES*OUTS-1). m_data, m_idx and m_last are registered.
REQ-027 DRAIN: on m_valid and m_ready, advance idx. When m_valid, m_ready and m_last are all high, pulse done next cycle -> IDLE.
REQ-028 While m_valid=1 and m_ready=0, m_data, m_idx and m_last SHALL hold stable.
REQ-029 start is ignored outside IDLE.
REQ-030 start in the same cycle as done SHALL still be accepted: it is sampled once the state is IDLE. At most one start is queued.
REQ-031 The buffer SHALL hold NODES*OUTS x DW bits.
REQ-032 Data path is pure storage; no arithmetic on result values.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE and clear the captured mask, timeout counter, idx and buffer.
REQ-034 Reset values: in_ready=0, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, done=0, err=0.
REQ-035 Reset asserted mid-WAIT or mid-DRAIN SHALL abort the transfer: m_valid drops immediately and no done pulse is produced.
REQ-036 Release of rst_n SHALL be synchronised by the instantiating level; this block assumes a synchronous deassert.

Structure
REQ-037 A shared package gnn_pkg SHALL hold the FSM state enum and the NODES, OUTS and DW constants, shared with the GNN top level.
REQ-038 The output stage (idx counter plus valid/hold register) SHALL be one sub-module, gnn_stream_out.

Verification
REQ-039 Scenario 1 (all flags together): start, then all 8 flags high at WAIT cycle 3 with res_data[k]=k+100. Expect in_ready for one cycle, then words 100..107 with m_idx 0..7, m_last on 107, then done.
REQ-040 Scenario 2 (staggered flags): flags rise one per cycle in order 7..0 and each value changes after its capture. Expect the streamed words to be the first-captured values.
REQ-041 Scenario 3 (backpressure): m_ready toggles 1,0,0,1,... Expect no word dropped or duplicated, and m_data stable while stalled.
REQ-042 Scenario 4 (timeout): TIMEOUT=10, only 7 flags ever rise. Expect err=1 at cycle 10, return to IDLE, no m_valid. A following start clears err.
REQ-043 Scenario 5 (completion vs timeout): the last flag rises on exactly the TIMEOUT cycle. Expect DRAIN and err=0.
REQ-044 Scenario 6 (reset mid-DRAIN): pull rst_n low after word 3. Expect all outputs return to reset values, and a subsequent start streams 8 fresh words.
